// File: rtl/mult_fu_pipe_pkg.sv
// Shared types for the issue/complete path: multiply function codes and the
// packets exchanged between the issue stage, the functional units and the CDB.
package sys_defs;
   localparam int XLEN   = 32;
   localparam int PREG_W = 6;
   localparam int ROB_W  = 5;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } MULT_FUNC;

   typedef struct packed {
      logic              valid;
      MULT_FUNC          func;
      logic [XLEN-1:0]   opa_value;
      logic [XLEN-1:0]   opb_value;
      logic [PREG_W-1:0] dest_preg;
      logic [ROB_W-1:0]  rob_entry;
   } ISSUE_FU_PACKET;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   value;
      logic [PREG_W-1:0] dest_preg;
      logic [ROB_W-1:0]  rob_entry;
   } FU_COMPLETE_PACKET;
endpackage

// File: rtl/mult_fu_pipe_if.sv
// Issue/complete handshake bundle between the issue stage + CDB arbiter
// (master) and one multiply unit (slave).
interface mult_fu_pipe_if;
   import sys_defs::*;

   logic              squash;
   ISSUE_FU_PACKET    iss_pkt;
   logic              fu_ready;
   FU_COMPLETE_PACKET cpl_pkt;
   logic              cpl_grant;

   modport master (output squash, output iss_pkt, output cpl_grant,
                   input fu_ready, input cpl_pkt);
   modport slave  (input squash, input iss_pkt, input cpl_grant,
                   output fu_ready, output cpl_pkt);
endinterface

// File: rtl/mult_pp_stage.sv
// One partial-product step of the multiplier: adds one CHUNK of the multiplier
// times the shifted multiplicand, registered with hold-when-blocked behaviour.
module mult_pp_stage
   import sys_defs::*;
#(
   parameter int STAGES = 4,
   parameter int K      = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              squash,
   input  logic              in_v,
   input  MULT_FUNC          in_func,
   input  logic [PREG_W-1:0] in_preg,
   input  logic [ROB_W-1:0]  in_rob,
   input  logic [2*XLEN-1:0] in_mcand,
   input  logic [2*XLEN-1:0] in_mplier,
   input  logic [2*XLEN-1:0] in_sum,
   input  logic              dn_ready,
   output logic              ready,
   output logic              out_v,
   output MULT_FUNC          out_func,
   output logic [PREG_W-1:0] out_preg,
   output logic [ROB_W-1:0]  out_rob,
   output logic [2*XLEN-1:0] out_mcand,
   output logic [2*XLEN-1:0] out_mplier,
   output logic [2*XLEN-1:0] out_sum
);
   localparam int W     = 2 * XLEN;
   localparam int CHUNK = W / STAGES;

   logic              v_q, v_d;
   MULT_FUNC          func_q, func_d;
   logic [PREG_W-1:0] preg_q, preg_d;
   logic [ROB_W-1:0]  rob_q, rob_d;
   logic [W-1:0]      mcand_q, mcand_d, mplier_q, mplier_d, sum_q, sum_d;
   logic [W-1:0]      chunk_ext, pp;

   always_comb begin
      // Accept new contents when empty or when the current occupant moves on.
      ready     = !v_q || dn_ready;
      chunk_ext = W'(in_mplier[K*CHUNK +: CHUNK]);
      pp        = (in_mcand * chunk_ext) << (K * CHUNK);
      v_d       = v_q;
      func_d    = func_q;
      preg_d    = preg_q;
      rob_d     = rob_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      sum_d     = sum_q;
      if (ready) begin
         v_d      = in_v;
         func_d   = in_func;
         preg_d   = in_preg;
         rob_d    = in_rob;
         mcand_d  = in_mcand;
         mplier_d = in_mplier;
         sum_d    = in_sum + pp;
      end
      if (squash) v_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v_q <= 1'b0;
      else        v_q <= v_d;
   end

   always_ff @(posedge clk) begin
      func_q   <= func_d;
      preg_q   <= preg_d;
      rob_q    <= rob_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sum_q    <= sum_d;
   end

   assign out_v      = v_q;
   assign out_func   = func_q;
   assign out_preg   = preg_q;
   assign out_rob    = rob_q;
   assign out_mcand  = mcand_q;
   assign out_mplier = mplier_q;
   assign out_sum    = sum_q;
endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined integer multiply unit: operand prep, STAGES partial-product steps
// and a result register held until the CDB arbiter grants it.
module mult_fu_pipe
   import sys_defs::*;
#(
   parameter int STAGES = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mult_fu_pipe_if.slave fu
);
   localparam int W = 2 * XLEN;

   // Index 0 is the captured packet; index k+1 is the output of stage k.
   logic              st_v      [STAGES+1];
   MULT_FUNC          st_func   [STAGES+1];
   logic [PREG_W-1:0] st_preg   [STAGES+1];
   logic [ROB_W-1:0]  st_rob    [STAGES+1];
   logic [W-1:0]      st_mcand  [STAGES+1];
   logic [W-1:0]      st_mplier [STAGES+1];
   logic [W-1:0]      st_sum    [STAGES+1];
   logic              st_rdy    [STAGES+1];

   logic              rest_full, fu_ready_w, out_load;
   logic [W-1:0]      prep_a, prep_b;
   logic              cpl_valid_q, cpl_valid_d;
   logic [XLEN-1:0]   cpl_value_q, cpl_value_d;
   logic [PREG_W-1:0] cpl_preg_q, cpl_preg_d;
   logic [ROB_W-1:0]  cpl_rob_q, cpl_rob_d;

   always_comb begin
      rest_full = 1'b1;
      for (int k = 1; k < STAGES; k++) rest_full = rest_full & st_v[k+1];
   end

   // Conservative on purpose: depends only on registered valid bits.
   assign fu_ready_w  = !st_v[1] || !rest_full || !cpl_valid_q;
   assign fu.fu_ready = fu_ready_w;
   assign out_load    = !cpl_valid_q || fu.cpl_grant;

   always_comb begin
      prep_a = {{XLEN{1'b0}}, fu.iss_pkt.opa_value};
      prep_b = {{XLEN{1'b0}}, fu.iss_pkt.opb_value};
      unique case (fu.iss_pkt.func)
         MULH: begin
            prep_a = {{XLEN{fu.iss_pkt.opa_value[XLEN-1]}}, fu.iss_pkt.opa_value};
            prep_b = {{XLEN{fu.iss_pkt.opb_value[XLEN-1]}}, fu.iss_pkt.opb_value};
         end
         MULHSU: prep_a = {{XLEN{fu.iss_pkt.opa_value[XLEN-1]}}, fu.iss_pkt.opa_value};
         default: ;
      endcase
   end

   assign st_v[0]      = fu.iss_pkt.valid && fu_ready_w && st_rdy[0];
   assign st_func[0]   = fu.iss_pkt.func;
   assign st_preg[0]   = fu.iss_pkt.dest_preg;
   assign st_rob[0]    = fu.iss_pkt.rob_entry;
   assign st_mcand[0]  = prep_a;
   assign st_mplier[0] = prep_b;
   assign st_sum[0]    = '0;
   assign st_rdy[STAGES] = out_load;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      mult_pp_stage #(.STAGES(STAGES), .K(gi)) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .squash     (fu.squash),
         .in_v       (st_v[gi]),
         .in_func    (st_func[gi]),
         .in_preg    (st_preg[gi]),
         .in_rob     (st_rob[gi]),
         .in_mcand   (st_mcand[gi]),
         .in_mplier  (st_mplier[gi]),
         .in_sum     (st_sum[gi]),
         .dn_ready   (st_rdy[gi+1]),
         .ready      (st_rdy[gi]),
         .out_v      (st_v[gi+1]),
         .out_func   (st_func[gi+1]),
         .out_preg   (st_preg[gi+1]),
         .out_rob    (st_rob[gi+1]),
         .out_mcand  (st_mcand[gi+1]),
         .out_mplier (st_mplier[gi+1]),
         .out_sum    (st_sum[gi+1])
      );
   end

   always_comb begin
      cpl_valid_d = cpl_valid_q;
      cpl_value_d = cpl_value_q;
      cpl_preg_d  = cpl_preg_q;
      cpl_rob_d   = cpl_rob_q;
      if (out_load) begin
         cpl_valid_d = st_v[STAGES];
         cpl_value_d = (st_func[STAGES] == MUL) ? st_sum[STAGES][XLEN-1:0]
                                                : st_sum[STAGES][W-1:XLEN];
         cpl_preg_d  = st_preg[STAGES];
         cpl_rob_d   = st_rob[STAGES];
      end
      if (fu.squash) cpl_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpl_valid_q <= 1'b0;
         cpl_value_q <= '0;
         cpl_preg_q  <= '0;
         cpl_rob_q   <= '0;
      end else begin
         cpl_valid_q <= cpl_valid_d;
         cpl_value_q <= cpl_value_d;
         cpl_preg_q  <= cpl_preg_d;
         cpl_rob_q   <= cpl_rob_d;
      end
   end

   assign fu.cpl_pkt = {cpl_valid_q, cpl_value_q, cpl_preg_q, cpl_rob_q};
endmodule
